// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit holding the architectural HI/LO registers.
// Latency: MULT_CYCLES/DIV_CYCLES busy cycles after acceptance; HI/LO update on the last edge.
// Backpressure: md_stall holds a dependent D-stage instruction during start and busy cycles.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] E_V1,
    input  logic [31:0] E_V2,
    input  logic [3:0]  E_mdop,
    input  logic        D_md_use,
    output logic [31:0] E_md_out,
    output logic        E_busy,
    output logic [31:0] E_HI,
    output logic [31:0] E_LO,
    output logic        md_stall
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
    localparam logic [3:0] MULT_N   = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N    = 4'(DIV_CYCLES);

    logic [31:0] hi_q, lo_q, pend_hi_q, pend_lo_q;
    logic [3:0]  cnt_q;
    logic        pend_wr_q;
    logic        busy, start, is_mul;

    assign busy   = (cnt_q != 4'd0);
    assign is_mul = (E_mdop == OP_MULT) || (E_mdop == OP_MULTU);
    assign start  = reset && !busy && (E_mdop >= OP_MULT) && (E_mdop <= OP_DIVU);

    // Signed divide is done on magnitudes so 0x80000000 / -1 wraps cleanly instead of trapping.
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] a_mag, b_mag, b_safe, u_safe;
    logic        [31:0] mq, mr, sq, sr, uq, ur;
    logic               a_neg, b_neg, div_zero;

    assign prod_s   = $signed(E_V1) * $signed(E_V2);
    assign prod_u   = {32'd0, E_V1} * {32'd0, E_V2};
    assign a_neg    = E_V1[31];
    assign b_neg    = E_V2[31];
    assign a_mag    = a_neg ? (32'd0 - E_V1) : E_V1;
    assign b_mag    = b_neg ? (32'd0 - E_V2) : E_V2;
    assign div_zero = (E_V2 == 32'd0);
    assign b_safe   = div_zero ? 32'd1 : b_mag;
    assign u_safe   = div_zero ? 32'd1 : E_V2;
    assign mq       = a_mag / b_safe;
    assign mr       = a_mag % b_safe;
    assign sq       = (a_neg ^ b_neg) ? (32'd0 - mq) : mq;
    assign sr       = a_neg ? (32'd0 - mr) : mr;
    assign uq       = E_V1 / u_safe;
    assign ur       = E_V1 % u_safe;

    logic [31:0] res_hi, res_lo;
    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (E_mdop)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_DIV:   begin res_hi = sr; res_lo = sq; end
            OP_DIVU:  begin res_hi = ur; res_lo = uq; end
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
            cnt_q     <= 4'd0;
        end else if (start) begin
            pend_hi_q <= res_hi;
            pend_lo_q <= res_lo;
            pend_wr_q <= is_mul || !div_zero;
            cnt_q     <= is_mul ? MULT_N : DIV_N;
        end else if (busy) begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1 && pend_wr_q) begin
                hi_q <= pend_hi_q;
                lo_q <= pend_lo_q;
            end
        end else if (E_mdop == OP_MTHI) begin
            hi_q <= E_V1;
        end else if (E_mdop == OP_MTLO) begin
            lo_q <= E_V1;
        end
    end

    always_comb begin
        E_md_out = 32'd0;
        if (E_mdop == OP_MFHI)      E_md_out = hi_q;
        else if (E_mdop == OP_MFLO) E_md_out = lo_q;
    end

    assign E_busy   = busy;
    assign E_HI     = hi_q;
    assign E_LO     = lo_q;
    assign md_stall = reset && D_md_use && (start || busy);
endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: hand-computed HI/LO results, busy timing, stall and reset behaviour.
module tb_e_mdu;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] E_V1, E_V2;
    logic [3:0]  E_mdop;
    logic        D_md_use;
    logic [31:0] E_md_out, E_HI, E_LO;
    logic        E_busy, md_stall;
    int total = 0;
    int bad   = 0;

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .E_V1(E_V1), .E_V2(E_V2), .E_mdop(E_mdop),
        .D_md_use(D_md_use), .E_md_out(E_md_out), .E_busy(E_busy),
        .E_HI(E_HI), .E_LO(E_LO), .md_stall(md_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a multi-cycle op and check busy/stall/HI/LO through every busy cycle and after.
    task automatic run_op(input logic [3:0] op, input logic [31:0] v1, input logic [31:0] v2,
                          input int n, input logic use_d,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic [31:0] old_hi, old_lo;
        old_hi = E_HI;
        old_lo = E_LO;
        E_V1 = v1; E_V2 = v2; E_mdop = op; D_md_use = use_d;
        #1;
        chk("start_stall", {31'd0, md_stall}, {31'd0, use_d});
        tick();
        E_mdop = 4'd0;
        for (int i = 0; i < n; i++) begin
            chk("busy_hi", {31'd0, E_busy}, 32'd1);
            chk("busy_stall", {31'd0, md_stall}, {31'd0, use_d});
            chk("busy_old_hi", E_HI, old_hi);
            chk("busy_old_lo", E_LO, old_lo);
            tick();
        end
        chk("done_busy", {31'd0, E_busy}, 32'd0);
        chk("done_stall", {31'd0, md_stall}, 32'd0);
        chk("done_hi", E_HI, exp_hi);
        chk("done_lo", E_LO, exp_lo);
        D_md_use = 1'b0;
    endtask

    task automatic mt(input logic [3:0] op, input logic [31:0] v);
        E_mdop = op; E_V1 = v;
        tick();
        E_mdop = 4'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; E_V1 = 32'd5; E_V2 = 32'd3; E_mdop = 4'd1; D_md_use = 1'b1;
        repeat (3) tick();
        chk("rst_hi", E_HI, 32'd0);
        chk("rst_lo", E_LO, 32'd0);
        chk("rst_busy", {31'd0, E_busy}, 32'd0);
        chk("rst_stall", {31'd0, md_stall}, 32'd0);
        chk("rst_out", E_md_out, 32'd0);
        E_mdop = 4'd0; D_md_use = 1'b0;
        reset = 1'b1;
        repeat (2) tick();
        chk("post_rst_hi", E_HI, 32'd0);
        chk("post_rst_busy", {31'd0, E_busy}, 32'd0);

        run_op(4'd1, 32'hFFFF_FFFE, 32'd3, 5, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op(4'd2, 32'hFFFF_FFFE, 32'd3, 5, 1'b0, 32'h0000_0002, 32'hFFFF_FFFA);
        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 10, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op(4'd4, 32'd7, 32'd2, 10, 1'b0, 32'd1, 32'd3);

        mt(4'd7, 32'h11);
        mt(4'd8, 32'h22);
        chk("mthi_11", E_HI, 32'h11);
        chk("mtlo_22", E_LO, 32'h22);
        run_op(4'd3, 32'd5, 32'd0, 10, 1'b1, 32'h11, 32'h22);
        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b0, 32'd0, 32'h8000_0000);

        mt(4'd7, 32'hDEAD_BEEF);
        chk("mthi_dead", E_HI, 32'hDEAD_BEEF);
        E_mdop = 4'd5; #1;
        chk("mfhi", E_md_out, 32'hDEAD_BEEF);
        E_mdop = 4'd6; #1;
        chk("mflo", E_md_out, 32'h8000_0000);
        E_mdop = 4'd0; #1;
        chk("md_out_none", E_md_out, 32'd0);

        // MTLO while a MULT 2*3 is busy must be dropped.
        E_V1 = 32'd2; E_V2 = 32'd3; E_mdop = 4'd1;
        tick();
        E_mdop = 4'd8; E_V1 = 32'h55;
        tick();
        E_mdop = 4'd0;
        repeat (4) tick();
        chk("mtlo_busy_busy", {31'd0, E_busy}, 32'd0);
        chk("mtlo_busy_lo", E_LO, 32'd6);
        chk("mtlo_busy_hi", E_HI, 32'd0);

        // Reset in busy cycle 4 of a DIV 100/7.
        E_V1 = 32'd100; E_V2 = 32'd7; E_mdop = 4'd3;
        tick();
        E_mdop = 4'd0;
        repeat (3) tick();
        chk("pre_rst_busy", {31'd0, E_busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, E_busy}, 32'd0);
        chk("midrst_lo", E_LO, 32'd0);
        chk("midrst_hi", E_HI, 32'd0);
        tick();
        reset = 1'b1;
        repeat (12) tick();
        chk("after_rst_hi", E_HI, 32'd0);
        chk("after_rst_lo", E_LO, 32'd0);
        chk("after_rst_busy", {31'd0, E_busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
